// File: rtl/register_file_pkg.sv
// register_file shared types and default geometry.
// Defaults are also used by decode to size register indexes.
package register_file_pkg;

    // Clear-sweep sequencer states
    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } rf_state_e;

    localparam int RF_DATA_W = 8;
    localparam int RF_ADDR_W = 3;

endpackage

// File: rtl/register_file_clear_seq.sv
// Clear-sweep sequencer: zeroes every entry after reset or on clr_req.
// Owns the FSM, the sweep counter and clr_busy.
module register_file_clear_seq
    import register_file_pkg::*;
#(
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              swp_we,
    output logic [ADDR_W-1:0] swp_idx
);

    localparam logic [ADDR_W-1:0] LAST_IDX = '1;

    rf_state_e         state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    // State and sweep counter registers; reset starts a fresh sweep
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: sweep one entry per cycle, re-arm from IDLE on clr_req
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_IDX) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            IDLE: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    assign clr_busy = (state_q == CLEAR);
    assign swp_we   = clr_busy;
    assign swp_idx  = cnt_q;

endmodule

// File: rtl/register_file.sv
// Two-read / one-write register file with hardware clear sweep.
// Define REGISTER_FILE_BYPASS_EN for write-first collisions (default read-first).
module register_file
    import register_file_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter bit ZERO_REG = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] ri_a,
    input  logic [ADDR_W-1:0] ri_b,
    input  logic              re,
    input  logic [ADDR_W-1:0] ri_d,
    input  logic              we,
    input  logic [DATA_W-1:0] d,
    input  logic              clr_req,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
    output logic              clr_busy
);

    localparam int REG_COUNT = 1 << ADDR_W;

    logic [DATA_W-1:0] bank_q [REG_COUNT];
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic              swp_we;
    logic [ADDR_W-1:0] swp_idx;
    logic              usr_we;

    register_file_clear_seq #(
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_req  (clr_req),
        .clr_busy (clr_busy),
        .swp_we   (swp_we),
        .swp_idx  (swp_idx)
    );

    // Writes to r0 are dropped when it is hardwired to zero
    assign usr_we = we && !clr_busy && !(ZERO_REG && (ri_d == '0));

    // Storage: sweep has priority and locks out the user write port
    always_ff @(posedge clk) begin
        if (swp_we) begin
            bank_q[swp_idx] <= '0;
        end else if (usr_we) begin
            bank_q[ri_d] <= d;
        end
    end

    // Read data selection: optional bypass, zero register, zero during sweep
    always_comb begin
        a_d = bank_q[ri_a];
        b_d = bank_q[ri_b];
`ifdef REGISTER_FILE_BYPASS_EN
        if (we && !clr_busy) begin
            if (ri_a == ri_d) a_d = d;
            if (ri_b == ri_d) b_d = d;
        end
`endif
        if (ZERO_REG && (ri_a == '0)) a_d = '0;
        if (ZERO_REG && (ri_b == '0)) b_d = '0;
        if (clr_busy) begin
            a_d = '0;
            b_d = '0;
        end
    end

    // Registered read ports, updated only on re
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
        end else if (re) begin
            a_q <= a_d;
            b_q <= b_d;
        end
    end

    assign a = a_q;
    assign b = b_q;

endmodule

// File: doc/register_file.md
# register_file

Parametrised successor of the DiBU 8x8 register bank: a DATA_W-bit, 2^ADDR_W-entry register file with two independent registered read ports and one write port. Unlike the previous bank, reads and writes proceed in the same cycle, contents are zeroed by a hardware clear sweep after reset or on request, and register 0 can be hardwired to zero. It sits between decode and the ALU in the DiBU datapath.

## Interface

- DATA_W, 8, register width in bits
- ADDR_W, 3, index width; REG_COUNT = 2^ADDR_W entries
- ZERO_REG, 0, when 1 register 0 always reads 0 and writes to it are dropped
- clk  input  1  main clock, all state on posedge
- rst_n  input  1  asynchronous, active-low reset
- ri_a, ri_b  input  ADDR_W  read indexes for ports a, b
- re  input  1  read enable; a, b update only when 1
- ri_d  input  ADDR_W  write index
- we  input  1  write enable
- d  input  DATA_W  write data
- clr_req  input  1  request a full clear sweep (level, sampled in IDLE)
- a, b  output  DATA_W  registered read data
- clr_busy  output  1  clear sweep in progress; high while contents are not yet valid

## Operation

- Reset (rst_n low, async): a = 0, b = 0, clr_busy = 1, sweep counter = 0, FSM = CLEAR. Array contents are not reset directly; they are zeroed by the sweep.
- FSM states: CLEAR, IDLE.
  - CLEAR: each cycle write 0 to bank[cnt] and increment cnt; at cnt = REG_COUNT-1, write it, go to IDLE, and drop clr_busy on the same edge. Duration is exactly REG_COUNT cycles.
  - IDLE: normal access. If clr_req = 1, go to CLEAR with cnt = 0 and raise clr_busy next edge. A we in that same cycle is still performed, then overwritten by the sweep.
- During CLEAR: we is ignored, clr_req is ignored (no restart), and a, b load 0 when re = 1.
- Write (IDLE, we = 1): bank[ri_d] <= d. With ZERO_REG = 1 and ri_d = 0, the write is dropped.
- Read (re = 1): a <= bank[ri_a], b <= bank[ri_b]. With ZERO_REG = 1, index 0 returns 0. When re = 0, a and b hold their values.
- A read and a write in the same cycle are both performed. Read/write collision handling on the same index is set by the configuration macro.
- rst_n asserted mid-sweep or mid-access restarts a full sweep from cnt = 0.

## Timing

- Read latency is 1 cycle: index presented at edge N, data valid after edge N.
- Write latency is 1 cycle: a write at edge N is visible to a read sampled at edge N+1.
- Clear: after rst_n deasserts, the first IDLE cycle is REG_COUNT posedges later. After clr_req is sampled in IDLE, clr_busy is high for REG_COUNT cycles.
- No combinational path from inputs to outputs.

## Configuration

- REGISTER_FILE_BYPASS_EN defined: when re, we, IDLE, and ri_a == ri_d (or ri_b == ri_d), that port returns the d being written (write-first). ZERO_REG still forces index 0 to 0.
- Not defined: a collision returns the pre-write contents (read-first), matching the old bank's ordering.

## Structure

- Package register_file_pkg holds:
  - the FSM state typedef (CLEAR, IDLE)
  - default DATA_W/ADDR_W localparams shared with decode
- One sub-module, register_file_clear_seq, owns the FSM, the ADDR_W-bit sweep counter, and clr_busy. It outputs the sweep write index and a sweep-write strobe that the top level muxes onto the write port.

## Test plan

- Reset then idle, DATA_W=8, ADDR_W=3: clr_busy = 1 for exactly 8 cycles after rst_n rises. Then read all indexes: a = b = 0x00.
- Write 0xA5 to r3, then read ri_a = 3, ri_b = 3 the next cycle: a = b = 0xA5 one cycle later. With re = 0, a and b hold their previous values.
- Same-cycle we r5 = 0x3C with re ri_a = 5 (r5 was 0x11): a = 0x3C with REGISTER_FILE_BYPASS_EN defined, a = 0x11 without it. The following read gives 0x3C in both builds.
- ZERO_REG = 1: write 0xFF to r0, then read r0, giving 0x00; write 0xFF to r1, then read r1, giving 0xFF.
- Load r0..r7 = 1..8, pulse clr_req: clr_busy high for 8 cycles, we during the sweep is ignored, and all registers read 0x00 afterwards.
- Assert rst_n mid-sweep at cnt = 4: a, b = 0 immediately (async), and a fresh 8-cycle sweep starts after release.
